// File: rtl/tdm_demux_pkg.sv
// Shared constants and FSM state type for the 1:8 TDM demultiplexer.
// The optional error counter is enabled by TDM_DEMUX_ERR_CNT_EN.
package tdm_demux_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM demultiplexer.
// Control priority is clr over load1 over inc.
module tdm_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SLOT_W'(1);
        end else if (inc) begin
            slot <= slot + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_1x8.sv
// 1:8 TDM demultiplexer: collects eight serial slots into a parallel frame.
// Define TDM_DEMUX_ERR_CNT_EN to add the saturating err_cnt output.
module tdm_demux_1x8
    import tdm_demux_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          din,
    input  logic                  din_valid,
    input  logic                  frame_sync,
    output logic [NUM_SLOTS*W-1:0] dout,
    output logic                  dout_valid,
    output logic [SLOT_W-1:0]     slot,
    output logic                  frame_err
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    state_e                 state;
    logic [NUM_SLOTS*W-1:0] shadow;
    logic [NUM_SLOTS*W-1:0] frame_nxt;
    logic                   sync_hit;
    logic                   data_hit;
    logic                   abort;
    logic                   last;
    logic                   wr_en;
    logic [SLOT_W-1:0]      wr_idx;

    assign sync_hit = din_valid & frame_sync;
    assign data_hit = din_valid & ~frame_sync & (state == ACTIVE);
    assign abort    = sync_hit & (state == ACTIVE);
    assign last     = data_hit & (slot == LAST_SLOT);
    assign wr_en    = sync_hit | data_hit;
    assign wr_idx   = sync_hit ? '0 : slot;

    // The slot-7 sample bypasses the shadow so dout lands one edge after it.
    always_comb begin
        frame_nxt = shadow;
        frame_nxt[(NUM_SLOTS-1)*W +: W] = din;
    end

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (last),
        .load1 (sync_hit),
        .inc   (data_hit),
        .slot  (slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            shadow     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_valid <= last;
            frame_err  <= abort;
            if (last) begin
                dout <= frame_nxt;
            end
            if (sync_hit) begin
                state <= ACTIVE;
            end else if (last) begin
                state <= HUNT;
            end
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (wr_en && (wr_idx == SLOT_W'(k))) begin
                    shadow[k*W +: W] <= din;
                end
            end
        end
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (frame_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed self-checking bench for tdm_demux_1x8 (W=1).
// Covers the TDM_DEMUX_ERR_CNT_EN counter when that macro is defined.
module tb_tdm_demux_1x8;

    logic       clk;
    logic       rst;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] slot;
    logic       frame_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int dv_seen  = 0;
    int fe_seen  = 0;

    tdm_demux_1x8 #(.W(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .frame_err  (frame_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dout_valid === 1'b1) dv_seen++;
        if (frame_err === 1'b1) fe_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic s, input logic d);
        din_valid  = 1'b1;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] f;
        int         dv0;
        int         fe0;

        rst        = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        #3;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_dv", 32'(dout_valid), 32'h0);
        chk("rst_slot", 32'(slot), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // contiguous frame 0x4D
        f = 8'h4D;
        for (int i = 0; i < 8; i++) begin
            send(i == 0, f[i]);
            chk("c_slot", 32'(slot), 32'((i + 1) % 8));
            chk("c_dv", 32'(dout_valid), 32'(i == 7));
        end
        chk("c_dout", 32'(dout), 32'h4D);
        idle();
        chk("c_dv_drop", 32'(dout_valid), 32'h0);
        chk("c_hold", 32'(dout), 32'h4D);

        // same frame with idle gaps after slots 2 and 5
        dv0 = dv_seen;
        for (int i = 0; i < 8; i++) begin
            send(i == 0, f[i]);
            chk("g_dv", 32'(dout_valid), 32'(i == 7));
            if (i == 2 || i == 5) begin
                for (int j = 0; j < 3; j++) begin
                    idle();
                    chk("g_hold_slot", 32'(slot), 32'(i + 1));
                    chk("g_hold_dv", 32'(dout_valid), 32'h0);
                end
            end
        end
        chk("g_dout", 32'(dout), 32'h4D);
        idle();
        chk("g_pulses", 32'(dv_seen - dv0), 32'h1);

        // early sync aborts a partial frame
        dv0 = dv_seen;
        fe0 = fe_seen;
        send(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1);
        chk("a_slot5", 32'(slot), 32'h5);
        f = 8'hA5;
        send(1'b1, f[0]);
        chk("a_ferr", 32'(frame_err), 32'h1);
        chk("a_slot1", 32'(slot), 32'h1);
        chk("a_dout_keep", 32'(dout), 32'h4D);
        for (int i = 1; i < 8; i++) begin
            send(1'b0, f[i]);
            chk("a_ferr_low", 32'(frame_err), 32'h0);
        end
        chk("a_dv", 32'(dout_valid), 32'h1);
        chk("a_dout", 32'(dout), 32'hA5);
        idle();
        chk("a_pulses", 32'(dv_seen - dv0), 32'h1);
        chk("a_errs", 32'(fe_seen - fe0), 32'h1);

        // no sync after reset: everything ignored
        do_reset();
        chk("h_rst_dout", 32'(dout), 32'h0);
        dv0 = dv_seen;
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 1'(i % 3 == 0));
            chk("h_slot", 32'(slot), 32'h0);
        end
        idle();
        chk("h_pulses", 32'(dv_seen - dv0), 32'h0);
        chk("h_dout", 32'(dout), 32'h0);

        // asynchronous reset mid-frame
        f = 8'h3C;
        for (int i = 0; i < 8; i++) send(i == 0, f[i]);
        chk("r_dout_pre", 32'(dout), 32'h3C);
        send(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1);
        chk("r_slot5", 32'(slot), 32'h5);
        #2;
        rst = 1'b1;
        #1;
        chk("r_async_slot", 32'(slot), 32'h0);
        chk("r_async_dout", 32'(dout), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dv0 = dv_seen;
        for (int i = 0; i < 8; i++) send(1'b0, 1'b1);
        chk("r_nosync_slot", 32'(slot), 32'h0);
        chk("r_nosync_dv", 32'(dv_seen - dv0), 32'h0);
        f = 8'h96;
        for (int i = 0; i < 8; i++) send(i == 0, f[i]);
        chk("r_dv", 32'(dout_valid), 32'h1);
        chk("r_dout", 32'(dout), 32'h96);

`ifdef TDM_DEMUX_ERR_CNT_EN
        do_reset();
        chk("e_rst", 32'(err_cnt), 32'h0);
        send(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 1'b1);
            send(1'b1, 1'b0);
            if (i == 9) begin
                idle();
                chk("e_ten", 32'(err_cnt), 32'd10);
            end
        end
        idle();
        idle();
        chk("e_sat", 32'(err_cnt), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x8.md
TDM_DEMUX_1X8 -- requirements
Module: tdm_demux_1x8

Interface
- REQ-001: Parameter W, default 1: bits per channel sample per slot.
- REQ-002: clk  input  1  rising-edge clock; the block has exactly one clock.
- REQ-003: rst  input  1  reset, asynchronous, active-high.
- REQ-004: din  input  W  serial TDM sample for the current slot.
- REQ-005: din_valid  input  1  din is valid this cycle.
- REQ-006: frame_sync  input  1  qualified by din_valid; marks din as slot 0 of a new frame.
- REQ-007: dout  output  8*W  completed frame; channel k occupies dout[k*W +: W].
- REQ-008: dout_valid  output  1  one-cycle pulse when dout is updated.
- REQ-009: slot  output  3  slot index the next accepted sample will be written to.
- REQ-010: frame_err  output  1  one-cycle pulse when a frame is aborted by an early frame_sync.

Function
- REQ-011: The FSM SHALL have two states: HUNT (discard samples, waiting for sync) and ACTIVE (collecting a frame).
- REQ-012: In HUNT, din_valid&&frame_sync SHALL write din to shadow slot 0, set slot=1 and enter ACTIVE; din_valid without frame_sync SHALL be ignored.
- REQ-013: In ACTIVE, each din_valid&&!frame_sync SHALL write din to shadow[slot] and increment slot.
- REQ-014: Cycles without din_valid SHALL hold all state; gaps between samples are unlimited.
- REQ-015: On acceptance of slot 7, the full shadow (including the slot-7 sample) SHALL load dout on the next edge with dout_valid=1 for exactly that cycle, and the FSM SHALL return to HUNT with slot=0.
- REQ-016: Latency SHALL be 1 cycle: dout_valid is asserted on the edge after the slot-7 sample is accepted.
- REQ-017: frame_sync with din_valid in ACTIVE at slot!=0 SHALL discard the partial frame, pulse frame_err, write din to slot 0, set slot=1 and remain in ACTIVE; dout SHALL NOT change.
- REQ-018: dout SHALL hold its last value between dout_valid pulses.
- REQ-019: Slot counter arithmetic SHALL be 3-bit; wrap from 7 to 0 occurs only through REQ-015.

Reset
- REQ-020: Asserting rst SHALL immediately force dout=0, dout_valid=0, frame_err=0, slot=0, shadow=0 and state HUNT, including mid-frame.
- REQ-021: After rst deasserts, the first frame SHALL require a fresh frame_sync.

Configuration
- REQ-022: With TDM_DEMUX_ERR_CNT_EN defined, an extra 8-bit output err_cnt SHALL count frame_err pulses, saturating at 255 and cleared by rst.
- REQ-023: Without TDM_DEMUX_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
- REQ-024: Package tdm_demux_pkg SHALL hold NUM_SLOTS=8, SLOT_W=3 and the HUNT/ACTIVE state enum.
- REQ-025: The slot counter with increment/clear/load-1 controls SHALL be the sub-module tdm_slot_ctr; all other logic is in tdm_demux_1x8.

Verification
- REQ-026: W=1, rst, then sync on 1, then bits 1,0,1,1,0,0,1,0 contiguous -> dout=8'b0100_1101 and a single dout_valid the cycle after the 8th bit.
- REQ-027: The same frame with 3 idle cycles inserted after slots 2 and 5 -> identical dout; dout_valid is delayed by 6 cycles.
- REQ-028: Sync, 4 samples, then sync again followed by a full frame of 0xA5 -> frame_err pulses once, dout=0xA5, and only one dout_valid.
- REQ-029: 20 valid samples without sync after reset -> slot stays 0, no dout_valid, dout=0.
- REQ-030: rst asserted asynchronously at slot 5 -> slot=0 and dout=0 before the next edge; the next frame completes only after a new sync.
- REQ-031: With TDM_DEMUX_ERR_CNT_EN, 300 aborted frames -> err_cnt=255 (saturated).
